// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-granular arbiter sharing one UDP TX header + payload path among NUM_PORTS requesters.
// Optional build macro UDP_TX_ARB_PRIORITY_EN selects fixed-priority (lowest index) instead of round-robin.
module udp_tx_arbiter #(
   parameter  int AXI_DATA_WIDTH = 8,
   parameter  int NUM_PORTS      = 4,
   localparam int GW             = $clog2(NUM_PORTS)
) (
   input  logic                                i_clk,
   input  logic                                i_reset_n,
   input  logic [NUM_PORTS-1:0]                s_hdr_tvalid,
   output logic [NUM_PORTS-1:0]                s_hdr_trdy,
   input  logic [NUM_PORTS*16-1:0]             s_udp_src_port,
   input  logic [NUM_PORTS*16-1:0]             s_udp_dst_port,
   input  logic [NUM_PORTS*32-1:0]             s_ip_src_addr,
   input  logic [NUM_PORTS*32-1:0]             s_ip_dst_addr,
   input  logic [NUM_PORTS*8-1:0]              s_ip_protocol,
   input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                s_axis_tlast,
   output logic [NUM_PORTS-1:0]                s_axis_trdy,
   output logic                                m_hdr_tvalid,
   input  logic                                m_hdr_trdy,
   output logic [15:0]                         m_udp_src_port,
   output logic [15:0]                         m_udp_dst_port,
   output logic [31:0]                         m_ip_src_addr,
   output logic [31:0]                         m_ip_dst_addr,
   output logic [7:0]                          m_ip_protocol,
   output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                                m_axis_tvalid,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_trdy,
   output logic [GW-1:0]                       o_grant,
   output logic                                o_busy
);

   localparam int PW  = 16;
   localparam int AW  = 32;
   localparam int PRW = 8;
   localparam int DW  = AXI_DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic          busy_q, busy_d;
   logic [GW-1:0] sel_s;
   logic          hdr_act_s;
   logic          pay_act_s;

   logic [PW-1:0]  src_port_a [NUM_PORTS];
   logic [PW-1:0]  dst_port_a [NUM_PORTS];
   logic [AW-1:0]  src_addr_a [NUM_PORTS];
   logic [AW-1:0]  dst_addr_a [NUM_PORTS];
   logic [PRW-1:0] proto_a    [NUM_PORTS];
   logic [DW-1:0]  tdata_a    [NUM_PORTS];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
      assign src_port_a[gi] = s_udp_src_port[PW*gi +: PW];
      assign dst_port_a[gi] = s_udp_dst_port[PW*gi +: PW];
      assign src_addr_a[gi] = s_ip_src_addr[AW*gi +: AW];
      assign dst_addr_a[gi] = s_ip_dst_addr[AW*gi +: AW];
      assign proto_a[gi]    = s_ip_protocol[PRW*gi +: PRW];
      assign tdata_a[gi]    = s_axis_tdata[DW*gi +: DW];
   end

`ifdef UDP_TX_ARB_PRIORITY_EN
   function automatic logic [GW-1:0] pick_next(input logic [NUM_PORTS-1:0] req);
      logic [GW-1:0] pick;
      pick = '0;
      // Scan downward so the lowest set index is the one that sticks
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[GW'(i)]) begin
            pick = GW'(i);
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   assign sel_s = pick_next(s_hdr_tvalid);
`else
   function automatic logic [GW-1:0] pick_next(input logic [NUM_PORTS-1:0] req,
                                                input logic [GW-1:0]        last);
      logic [GW-1:0] pick;
      logic [GW-1:0] idx;
      logic          found;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = GW'((int'(last) + k) % NUM_PORTS);
         if (req[idx] && !found) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   assign sel_s = pick_next(s_hdr_tvalid, last_grant_q);
`endif

   // Next state, grant capture and arbitration history
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (|s_hdr_tvalid) begin
               grant_d = sel_s;
               state_d = ST_HDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (m_hdr_tvalid && m_hdr_trdy) begin
               state_d = ST_PAYLOAD;
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_PAYLOAD: begin
            if (m_axis_tvalid && m_axis_trdy && m_axis_tlast) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_PAYLOAD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and grant registers
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_PORTS - 1);
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
      end
   end

   // Routing of the granted slice; reset also blocks any handshake in its own cycle
   always_comb begin
      hdr_act_s      = (state_q == ST_HDR) && i_reset_n;
      pay_act_s      = (state_q == ST_PAYLOAD) && i_reset_n;
      s_hdr_trdy     = '0;
      s_axis_trdy    = '0;
      m_hdr_tvalid   = 1'b0;
      m_udp_src_port = '0;
      m_udp_dst_port = '0;
      m_ip_src_addr  = '0;
      m_ip_dst_addr  = '0;
      m_ip_protocol  = '0;
      m_axis_tdata   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      if (hdr_act_s) begin
         m_hdr_tvalid        = s_hdr_tvalid[grant_q];
         s_hdr_trdy[grant_q] = m_hdr_trdy;
         m_udp_src_port      = src_port_a[grant_q];
         m_udp_dst_port      = dst_port_a[grant_q];
         m_ip_src_addr       = src_addr_a[grant_q];
         m_ip_dst_addr       = dst_addr_a[grant_q];
         m_ip_protocol       = proto_a[grant_q];
      end else begin
         m_hdr_tvalid = 1'b0;
      end
      if (pay_act_s) begin
         m_axis_tdata         = tdata_a[grant_q];
         m_axis_tvalid        = s_axis_tvalid[grant_q];
         m_axis_tlast         = s_axis_tlast[grant_q];
         s_axis_trdy[grant_q] = m_axis_trdy;
      end else begin
         m_axis_tvalid = 1'b0;
      end
   end

   assign o_grant = grant_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomised bench for udp_tx_arbiter: packet sources, a transaction-level arbitration model and a scoreboard.
`timescale 1ns/1ps
module tb_udp_tx_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;

   typedef struct packed {
      logic [15:0] sp;
      logic [15:0] dp;
      logic [31:0] sip;
      logic [31:0] dip;
      logic [7:0]  pr;
   } hdr_t;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic            i_reset_n;
   logic [N-1:0]    s_hdr_tvalid, s_hdr_trdy;
   logic [N*16-1:0] s_udp_src_port, s_udp_dst_port;
   logic [N*32-1:0] s_ip_src_addr, s_ip_dst_addr;
   logic [N*8-1:0]  s_ip_protocol;
   logic [N*DW-1:0] s_axis_tdata;
   logic [N-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_trdy;
   logic            m_hdr_tvalid, m_hdr_trdy;
   logic [15:0]     m_udp_src_port, m_udp_dst_port;
   logic [31:0]     m_ip_src_addr, m_ip_dst_addr;
   logic [7:0]      m_ip_protocol;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid, m_axis_tlast, m_axis_trdy;
   logic [1:0]      o_grant;
   logic            o_busy;

   udp_tx_arbiter #(.AXI_DATA_WIDTH(DW), .NUM_PORTS(N)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_trdy(s_hdr_trdy),
      .s_udp_src_port(s_udp_src_port), .s_udp_dst_port(s_udp_dst_port),
      .s_ip_src_addr(s_ip_src_addr), .s_ip_dst_addr(s_ip_dst_addr), .s_ip_protocol(s_ip_protocol),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_trdy(s_axis_trdy),
      .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_trdy(m_hdr_trdy),
      .m_udp_src_port(m_udp_src_port), .m_udp_dst_port(m_udp_dst_port),
      .m_ip_src_addr(m_ip_src_addr), .m_ip_dst_addr(m_ip_dst_addr), .m_ip_protocol(m_ip_protocol),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_trdy(m_axis_trdy), .o_grant(o_grant), .o_busy(o_busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Source-side packet store
   hdr_t       hdr_q [N][$];
   int         len_q [N][$];
   logic [7:0] pay_q [N][$];
   bit         hdr_done [N];
   int         beat [N];
   logic [N-1:0] hs_h, hs_a;
   bit         drop_partial, rst_req, gap_en;
   int         hrdy_mode, ardy_mode, hstall;

   // Transaction-level model of the arbiter
   bit mdl_free, mdl_in_hdr;
   int mdl_owner, mdl_last, mdl_gshown;
   int order_q[$];
   int hs_cyc_q[$];
   int cyc, beats_out;

   function automatic int pick(input logic [N-1:0] req, input int last);
`ifdef UDP_TX_ARB_PRIORITY_EN
      for (int i = 0; i < N; i++) if (req[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
`endif
      return 0;
   endfunction

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (hdr_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic hdr_t rand_hdr();
      hdr_t h;
      h.sp = 16'($urandom); h.dp = 16'($urandom);
      h.sip = $urandom; h.dip = $urandom; h.pr = 8'($urandom);
      return h;
   endfunction

   task automatic add_pkt(input int p, input hdr_t h, input int len, input int base);
      hdr_q[p].push_back(h);
      len_q[p].push_back(len);
      for (int k = 0; k < len; k++) pay_q[p].push_back(base < 0 ? 8'($urandom) : 8'(base + k));
   endtask

   task automatic monitor();
      logic [N-1:0] exp_v;
      bit lastb;
      hs_h = '0;
      hs_a = '0;
      if (mdl_free) begin
         check("idle_busy", o_busy, 0);
         check("idle_grant", o_grant, mdl_gshown);
         check("idle_valid", {m_hdr_tvalid, m_axis_tvalid, m_axis_tlast}, 0);
         check("idle_trdy", {s_hdr_trdy, s_axis_trdy}, 0);
         check("idle_zero", {m_udp_src_port, m_udp_dst_port, m_ip_src_addr, m_ip_dst_addr, m_ip_protocol, m_axis_tdata}, 0);
         if (s_hdr_tvalid != '0) begin
            mdl_owner  = pick(s_hdr_tvalid, mdl_last);
            mdl_gshown = mdl_owner;
            mdl_free   = 1'b0;
            mdl_in_hdr = 1'b1;
         end
      end else if (mdl_in_hdr) begin
         check("hdr_grant", o_grant, mdl_owner);
         check("hdr_busy", o_busy, 1);
         check("hdr_valid", m_hdr_tvalid, s_hdr_tvalid[mdl_owner]);
         exp_v = '0;
         exp_v[mdl_owner] = m_hdr_trdy;
         check("hdr_trdy", s_hdr_trdy, exp_v);
         check("hdr_no_payload", {m_axis_tvalid, s_axis_trdy}, 0);
         check("hdr_fields", {m_udp_src_port, m_udp_dst_port, m_ip_src_addr, m_ip_dst_addr, m_ip_protocol}, hdr_q[mdl_owner][0]);
         if (s_hdr_tvalid[mdl_owner] && m_hdr_trdy) begin
            hs_h[mdl_owner] = 1'b1;
            mdl_in_hdr = 1'b0;
            order_q.push_back(mdl_owner);
            hs_cyc_q.push_back(cyc);
         end
      end else begin
         check("pay_grant", o_grant, mdl_owner);
         check("pay_busy", o_busy, 1);
         check("pay_no_hdr", {m_hdr_tvalid, s_hdr_trdy}, 0);
         exp_v = '0;
         exp_v[mdl_owner] = m_axis_trdy;
         check("pay_trdy", s_axis_trdy, exp_v);
         check("pay_valid", m_axis_tvalid, s_axis_tvalid[mdl_owner]);
         if (s_axis_tvalid[mdl_owner]) begin
            lastb = (beat[mdl_owner] == len_q[mdl_owner][0] - 1);
            check("pay_data", m_axis_tdata, pay_q[mdl_owner][0]);
            check("pay_last", m_axis_tlast, lastb);
            if (m_axis_trdy) begin
               hs_a[mdl_owner] = 1'b1;
               beats_out++;
               if (lastb) begin
                  mdl_free = 1'b1;
                  mdl_last = mdl_owner;
               end
            end
         end
      end
   endtask

   task automatic update_sources();
      hdr_t h;
      for (int i = 0; i < N; i++) begin
         if (drop_partial && hdr_done[i]) begin
            for (int k = beat[i]; k < len_q[i][0]; k++) void'(pay_q[i].pop_front());
            void'(hdr_q[i].pop_front());
            void'(len_q[i].pop_front());
            hdr_done[i] = 1'b0;
            beat[i] = 0;
         end
         if (hs_h[i]) hdr_done[i] = 1'b1;
         if (hs_a[i]) begin
            void'(pay_q[i].pop_front());
            beat[i]++;
            if (beat[i] == len_q[i][0]) begin
               void'(hdr_q[i].pop_front());
               void'(len_q[i].pop_front());
               beat[i] = 0;
               hdr_done[i] = 1'b0;
            end
         end
         if (hdr_q[i].size() != 0) begin
            h = hdr_q[i][0];
            if (!hdr_done[i]) begin
               s_hdr_tvalid[i]  = gap_en ? ($urandom_range(3) != 0) : 1'b1;
               s_axis_tvalid[i] = 1'b0;
               s_axis_tlast[i]  = 1'b0;
            end else begin
               s_hdr_tvalid[i]  = 1'b0;
               s_axis_tvalid[i] = gap_en ? ($urandom_range(3) != 0) : 1'b1;
               s_axis_tdata[DW*i +: DW] = pay_q[i][0];
               s_axis_tlast[i]  = (beat[i] == len_q[i][0] - 1);
            end
         end else begin
            h = rand_hdr();
            s_hdr_tvalid[i]  = 1'b0;
            s_axis_tvalid[i] = 1'b0;
            s_axis_tlast[i]  = 1'($urandom);
            s_axis_tdata[DW*i +: DW] = 8'($urandom);
         end
         s_udp_src_port[16*i +: 16] = h.sp;
         s_udp_dst_port[16*i +: 16] = h.dp;
         s_ip_src_addr[32*i +: 32]  = h.sip;
         s_ip_dst_addr[32*i +: 32]  = h.dip;
         s_ip_protocol[8*i +: 8]    = h.pr;
      end
      drop_partial = 1'b0;
   endtask

   // One clock: observe at negedge, then update stimulus just after posedge
   task automatic cycle();
      @(negedge i_clk);
      cyc++;
      if (i_reset_n) begin
         monitor();
      end else begin
         hs_h = '0;
         hs_a = '0;
         mdl_free = 1'b1;
         mdl_in_hdr = 1'b0;
         mdl_last = N - 1;
         mdl_gshown = 0;
         drop_partial = 1'b1;
      end
      @(posedge i_clk);
      #1;
      update_sources();
      i_reset_n = !rst_req;
      rst_req = 1'b0;
      case (hrdy_mode)
         0: m_hdr_trdy = 1'b1;
         1: begin m_hdr_trdy = (hstall == 0); if (hstall > 0) hstall--; end
         default: m_hdr_trdy = 1'($urandom);
      endcase
      case (ardy_mode)
         0: m_axis_trdy = 1'b1;
         1: m_axis_trdy = ~m_axis_trdy;
         default: m_axis_trdy = 1'($urandom);
      endcase
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      cycle();
      cycle();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((pending() || !mdl_free) && n < budget) begin
         cycle();
         n++;
      end
      cycle();
      check({tag, "_drained"}, (n < budget), 1);
   endtask

   task automatic check_order(input string tag, input int exp[$]);
      check({tag, "_count"}, order_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < order_q.size(); i++) check({tag, "_order"}, order_q[i], exp[i]);
   endtask

   initial begin
      hdr_t h;
      int exp_ord[$];
      i_reset_n = 1'b0;
      s_hdr_tvalid = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0;
      s_udp_src_port = '0; s_udp_dst_port = '0; s_ip_src_addr = '0; s_ip_dst_addr = '0; s_ip_protocol = '0;
      m_hdr_trdy = 1'b1; m_axis_trdy = 1'b1;
      hrdy_mode = 0; ardy_mode = 0; hstall = 0; gap_en = 1'b0;
      mdl_free = 1'b1; mdl_in_hdr = 1'b0; mdl_last = N - 1; mdl_gshown = 0;
      cyc = 0; beats_out = 0; drop_partial = 1'b0;
      for (int i = 0; i < N; i++) begin hdr_done[i] = 1'b0; beat[i] = 0; end
      rst_req = 1'b1;
      cycle();
      cycle();
      repeat (3) cycle();

      // Single request from requester 2
      h.sp = 16'h1234; h.dp = 16'h0050; h.sip = 32'h0A000001; h.dip = 32'hC0A80001; h.pr = 8'h11;
      order_q.delete(); beats_out = 0;
      add_pkt(2, h, 5, 1);
      drain("single", 100);
      check("single_beats", beats_out, 5);
      exp_ord = '{2};
      check_order("single", exp_ord);

      // Simultaneous requests from 0, 1, 3, with requester 0 re-requesting
      do_reset();
      order_q.delete();
      add_pkt(0, rand_hdr(), 3, -1);
      add_pkt(0, rand_hdr(), 3, -1);
      add_pkt(1, rand_hdr(), 3, -1);
      add_pkt(3, rand_hdr(), 3, -1);
      drain("simul", 200);
`ifdef UDP_TX_ARB_PRIORITY_EN
      exp_ord = '{0, 0, 1, 3};
`else
      exp_ord = '{0, 1, 3, 0};
`endif
      check_order("simul", exp_ord);

      // Payload backpressure toggling 1010
      ardy_mode = 1; beats_out = 0;
      add_pkt(1, rand_hdr(), 6, 8'h40);
      drain("bp", 200);
      check("bp_beats", beats_out, 6);
      ardy_mode = 0;

      // Header stall for 10 cycles
      order_q.delete(); beats_out = 0;
      hrdy_mode = 1; hstall = 10;
      add_pkt(0, rand_hdr(), 4, -1);
      repeat (10) cycle();
      check("stall_no_hdr_hs", order_q.size(), 0);
      check("stall_no_beats", beats_out, 0);
      drain("stall", 100);
      check("stall_beats", beats_out, 4);
      hrdy_mode = 0;

      // Reset in the middle of an 8-beat packet; history must reinitialise
      add_pkt(1, rand_hdr(), 3, -1);
      drain("pre_rst", 100);
      add_pkt(2, rand_hdr(), 8, -1);
      for (int n = 0; n < 100 && beat[2] < 3; n++) cycle();
      check("rst_reach_beat3", beat[2], 3);
      add_pkt(0, rand_hdr(), 2, -1);
      add_pkt(3, rand_hdr(), 2, -1);
      do_reset();
      order_q.delete();
      drain("post_rst", 200);
      exp_ord = '{0, 3};
      check_order("post_rst", exp_ord);

      // Back-to-back single-beat packets from requester 3
      hs_cyc_q.delete();
      for (int k = 0; k < 4; k++) add_pkt(3, rand_hdr(), 1, -1);
      drain("b2b", 100);
      check("b2b_count", hs_cyc_q.size(), 4);
      for (int k = 1; k < hs_cyc_q.size(); k++) check("b2b_spacing", hs_cyc_q[k] - hs_cyc_q[k-1], 3);

      // Random traffic with gaps and random readies
      gap_en = 1'b1; hrdy_mode = 2; ardy_mode = 2; beats_out = 0;
      for (int k = 0; k < 40; k++) add_pkt($urandom_range(N - 1), rand_hdr(), $urandom_range(8, 1), -1);
      drain("rand", 8000);
      gap_en = 1'b0; hrdy_mode = 0; ardy_mode = 0;
      for (int k = 0; k < 20; k++) add_pkt($urandom_range(N - 1), rand_hdr(), $urandom_range(4, 1), -1);
      drain("rand_full", 2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
